lcd_text_driver: RTL and testbench

//  Consumes the 256-bit, 32-character ASCII frame built by the display formatter.

---
 rtl/lcd_text_driver.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// HD44780 2x16 text driver over the 4-bit write-only bus.
// Runs the power-up init once, then streams both lines from a per-frame snapshot of msg.
module lcd_text_driver #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EHIGH   = 12,
  parameter int unsigned T_NIBGAP  = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] msg,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         lcd_4,
  output logic         lcd_5,
  output logic         lcd_6,
  output logic         lcd_7,
  output logic         init_done,
  output logic         frame_pulse
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned TMax = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_CMD)),
                                      max2(max2(T_CLEAR, T_SETUP), max2(T_EHIGH, T_NIBGAP)));
  localparam int unsigned CntW = $clog2(TMax + 1);

  typedef enum logic [2:0] {
    StPwrWait, StInitNib, StCfg, StSetAddr1, StLine1, StSetAddr2, StLine2
  } state_e;

  // Phases of one write: nibble setup, enable high, gap before low nibble, post-write wait.
  typedef enum logic [1:0] {PhSetup, PhHigh, PhGap, PhWait} phase_e;

  state_e               st_q, st_d;
  phase_e               ph_q, ph_d;
  logic [3:0]           idx_q, idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 low_q, low_d;
  logic [3:0]           nib_q, nib_d;
  logic                 rs_q, rs_d;
  logic                 e_q, e_d;
  logic                 done_q, done_d;
  logic                 pulse_q, pulse_d;
  logic [31:0][7:0]     frame_q, frame_d;
  logic [7:0]           cur_byte;
  logic [7:0]           next_byte;
  logic [CntW-1:0]      wait_last;

  // frame[31] holds line1 col0, frame[0] holds line2 col15.
  function automatic logic [7:0] item_byte(input state_e st, input logic [3:0] idx,
                                           input logic [31:0][7:0] frame);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      StInitNib:  b = (idx == 4'd3) ? 8'h02 : 8'h03;
      StCfg: begin
        case (idx)
          4'd0:    b = 8'h28;
          4'd1:    b = 8'h06;
          4'd2:    b = 8'h0C;
          default: b = 8'h01;
        endcase
      end
      StSetAddr1: b = 8'h80;
      StSetAddr2: b = 8'hC0;
      StLine1:    b = frame[{1'b1, ~idx}];
      StLine2:    b = frame[{1'b0, ~idx}];
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic int unsigned item_wait(input state_e st, input logic [3:0] idx);
    int unsigned w;
    case (st)
      StPwrWait: w = T_POWERUP;
      StInitNib: w = (idx == 4'd0) ? T_INIT1 : ((idx == 4'd1) ? T_INIT2 : T_CMD);
      StCfg:     w = (idx == 4'd3) ? T_CLEAR : T_CMD;
      default:   w = T_CMD;
    endcase
    return w;
  endfunction

  assign cur_byte  = item_byte(st_q, idx_q, frame_q);
  assign wait_last = CntW'(item_wait(st_q, idx_q) - 1);

  always_comb begin
    st_d      = st_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CntW'(1);
    low_d     = low_q;
    nib_d     = nib_q;
    rs_d      = rs_q;
    e_d       = e_q;
    done_d    = done_q;
    pulse_d   = 1'b0;
    frame_d   = frame_q;
    next_byte = 8'h00;
    case (ph_q)
      PhSetup: begin
        if (cnt_q == CntW'(T_SETUP - 1)) begin
          ph_d  = PhHigh;
          cnt_d = '0;
          e_d   = 1'b1;
        end
      end
      PhHigh: begin
        if (cnt_q == CntW'(T_EHIGH - 1)) begin
          e_d   = 1'b0;
          cnt_d = '0;
          ph_d  = low_q ? PhWait : PhGap;
        end
      end
      PhGap: begin
        if (cnt_q == CntW'(T_NIBGAP - 1)) begin
          ph_d  = PhSetup;
          cnt_d = '0;
          low_d = 1'b1;
          nib_d = cur_byte[3:0];
        end
      end
      default: begin
        if (cnt_q == wait_last) begin
          ph_d  = PhSetup;
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
          case (st_q)
            StPwrWait: begin
              st_d  = StInitNib;
              idx_d = '0;
            end
            StInitNib: begin
              if (idx_q == 4'd3) begin
                st_d  = StCfg;
                idx_d = '0;
              end
            end
            StCfg: begin
              if (idx_q == 4'd3) begin
                st_d    = StSetAddr1;
                idx_d   = '0;
                done_d  = 1'b1;
                frame_d = msg;
              end
            end
            StSetAddr1: begin
              st_d  = StLine1;
              idx_d = '0;
            end
            StLine1: begin
              if (idx_q == 4'd15) begin
                st_d  = StSetAddr2;
                idx_d = '0;
              end
            end
            StSetAddr2: begin
              st_d  = StLine2;
              idx_d = '0;
            end
            StLine2: begin
              if (idx_q == 4'd15) begin
                st_d    = StSetAddr1;
                idx_d   = '0;
                pulse_d = 1'b1;
                frame_d = msg;
              end
            end
            default: begin
              st_d  = StPwrWait;
              idx_d = '0;
            end
          endcase
          // Init nibbles go out as a single low-nibble write.
          next_byte = item_byte(st_d, idx_d, frame_q);
          low_d     = (st_d == StInitNib);
          nib_d     = low_d ? next_byte[3:0] : next_byte[7:4];
          rs_d      = (st_d == StLine1) || (st_d == StLine2);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= StPwrWait;
      ph_q    <= PhWait;
      idx_q   <= '0;
      cnt_q   <= '0;
      low_q   <= 1'b0;
      nib_q   <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      frame_q <= '0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      frame_q <= frame_d;
    end
  end

  assign lcd_rs      = rs_q;
  assign lcd_rw      = 1'b0;
  assign lcd_e       = e_q;
  assign lcd_4       = nib_q[0];
  assign lcd_5       = nib_q[1];
  assign lcd_6       = nib_q[2];
  assign lcd_7       = nib_q[3];
  assign init_done   = done_q;
  assign frame_pulse = pulse_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench: stimulus pushes the expected strobe stream, a monitor decodes lcd_e falls.
module tb_lcd_text_driver;

  localparam int T_POWERUP = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 30;
  localparam int T_SETUP   = 2;
  localparam int T_EHIGH   = 12;
  localparam int T_NIBGAP  = 50;

  localparam int NibW     = T_SETUP + T_EHIGH;
  localparam int ByteP    = 2 * NibW + T_NIBGAP + T_CMD;
  localparam int FirstD   = T_POWERUP - 1;
  localparam int CfgD     = FirstD + 4 * NibW + T_INIT1 + T_INIT2 + 2 * T_CMD;
  localparam int Frame0D  = CfgD + 3 * ByteP + (2 * NibW + T_NIBGAP + T_CLEAR);
  localparam int FrameP   = 34 * ByteP;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] msg;
  logic         lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7, init_done, frame_pulse;

  lcd_text_driver #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
    .T_CLEAR(T_CLEAR), .T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_NIBGAP(T_NIBGAP)
  ) dut (
    .clk(clk), .reset(reset), .msg(msg), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7), .init_done(init_done),
    .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gap;
    logic       ido;
    int         pulses;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rw_viol = 0;
  int   stab_viol = 0;
  int   m_wait = 0;
  int   now_edge = -1;

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  // Reference model: each write becomes one or two strobes, gap = previous wait + setup + high.
  task automatic push_nib(input logic rs, input logic [3:0] n, input int gap, input logic ido,
                          input int pul);
    exp_t e;
    e.rs = rs; e.nib = n; e.gap = gap; e.ido = ido; e.pulses = pul;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b, input int wait_after,
                           input logic ido, input int pul);
    push_nib(rs, b[7:4], m_wait + NibW, ido, pul);
    push_nib(rs, b[3:0], T_NIBGAP + NibW, ido, 0);
    m_wait = wait_after;
  endtask

  task automatic push_init();
    m_wait = FirstD;
    push_nib(1'b0, 4'h3, m_wait + NibW, 1'b0, 0); m_wait = T_INIT1;
    push_nib(1'b0, 4'h3, m_wait + NibW, 1'b0, 0); m_wait = T_INIT2;
    push_nib(1'b0, 4'h3, m_wait + NibW, 1'b0, 0); m_wait = T_CMD;
    push_nib(1'b0, 4'h2, m_wait + NibW, 1'b0, 0); m_wait = T_CMD;
    push_byte(1'b0, 8'h28, T_CMD, 1'b0, 0);
    push_byte(1'b0, 8'h06, T_CMD, 1'b0, 0);
    push_byte(1'b0, 8'h0C, T_CMD, 1'b0, 0);
    push_byte(1'b0, 8'h01, T_CLEAR, 1'b0, 0);
  endtask

  task automatic push_frame(input logic [255:0] f, input int pul);
    push_byte(1'b0, 8'h80, T_CMD, 1'b1, pul);
    for (int i = 0; i < 16; i++) push_byte(1'b1, 8'(f >> (8 * (31 - i))), T_CMD, 1'b1, 0);
    push_byte(1'b0, 8'hC0, T_CMD, 1'b1, 0);
    for (int i = 0; i < 16; i++) push_byte(1'b1, 8'(f >> (8 * (15 - i))), T_CMD, 1'b1, 0);
  endtask

  function automatic logic [255:0] text_frame(input string l1, input string l2);
    logic [255:0] f;
    byte c;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      c = (i < l1.len()) ? l1[i] : 8'h20;
      f[255 - 8 * i -: 8] = c;
      c = (i < l2.len()) ? l2[i] : 8'h20;
      f[127 - 8 * i -: 8] = c;
    end
    return f;
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32 * i +: 32] = $urandom();
    return f;
  endfunction

  task automatic goto(input int t);
    while (now_edge < t) begin
      @(posedge clk);
      now_edge++;
    end
    #1;
  endtask

  // Monitor: edge index counted from reset release, sampled 1 time unit after each edge.
  initial begin : monitor
    int         cyc;
    int         last_fall;
    int         pulses;
    int         nstb;
    logic       prev_e;
    logic [4:0] bus, prev_bus;
    exp_t       ex;
    cyc = -1; last_fall = 0; pulses = 0; nstb = 0; prev_e = 1'b0; prev_bus = '0;
    forever begin
      @(posedge clk);
      #1;
      bus = {lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4};
      if (lcd_rw !== 1'b0) rw_viol++;
      if (reset) begin
        cyc = -1; last_fall = 0; pulses = 0; prev_e = 1'b0; prev_bus = bus;
      end else begin
        cyc++;
        if ((prev_e || lcd_e) && bus !== prev_bus) stab_viol++;
        if (frame_pulse) pulses++;
        if (prev_e && !lcd_e) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_strobe%0d", nstb), 1, 0);
          end else begin
            ex = exp_q.pop_front();
            chk($sformatf("strobe%0d_rs", nstb), int'(bus[4]), int'(ex.rs));
            chk($sformatf("strobe%0d_nibble", nstb), int'(bus[3:0]), int'(ex.nib));
            chk($sformatf("strobe%0d_gap", nstb), cyc - last_fall, ex.gap);
            chk($sformatf("strobe%0d_init_done", nstb), int'(init_done), int'(ex.ido));
            chk($sformatf("strobe%0d_frame_pulses", nstb), pulses, ex.pulses);
          end
          nstb++;
          last_fall = cyc;
          pulses = 0;
        end
        prev_e = lcd_e;
        prev_bus = bus;
      end
    end
  end

  initial begin : stimulus
    logic [255:0] f;
    reset = 1'b1;
    msg = text_frame("   CLOCK", "  12:34:56");
    repeat (3) @(posedge clk);
    push_init();
    push_frame(msg, 0);
    @(negedge clk);
    reset = 1'b0;
    now_edge = -1;

    // Change msg mid LINE1 char 5: current frame keeps its snapshot, next frame gets new text.
    for (int k = 0; k < 3; k++) begin
      goto(Frame0D + k * FrameP + 6 * ByteP + 20);
      f = rand_frame();
      msg = f;
      push_frame(f, 1);
    end

    // Reset while lcd_e is high on the high nibble of line2 char 7 of frame 3.
    goto(Frame0D + 3 * FrameP + 25 * ByteP + T_SETUP + 5);
    #2;
    chk("e_high_before_reset", int'(lcd_e), 1);
    chk("rs_before_reset", int'(lcd_rs), 1);
    reset = 1'b1;
    #1;
    chk("reset_lcd_e", int'(lcd_e), 0);
    chk("reset_lcd_rs", int'(lcd_rs), 0);
    chk("reset_data", int'({lcd_7, lcd_6, lcd_5, lcd_4}), 0);
    chk("reset_init_done", int'(init_done), 0);
    chk("reset_frame_pulse", int'(frame_pulse), 0);
    exp_q.delete();
    f = rand_frame();
    msg = f;
    push_init();
    push_frame(f, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    now_edge = -1;

    for (int i = 0; i < Frame0D + FrameP + 500 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending_strobes", exp_q.size(), 0);
    chk("lcd_rw_nonzero_cycles", rw_viol, 0);
    chk("bus_change_while_e_high", stab_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
